// File: rtl/grey_step_sched.sv
// grey_step_sched: round-robin scheduler that shares one 6-bit Gray-code
// counter among NREQ requesters. It paces single-cycle increment pulses for
// the granted requester, pulses o_done when the run finishes, and flags any
// counter step that does not change exactly one bit.
module grey_step_sched #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 6,
    parameter int GAP   = 1,
    localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NREQ-1:0]         i_req_valid,
    input  logic [NREQ*CNT_W-1:0]   i_req_steps,
    output logic [NREQ-1:0]         o_req_ready,
    output logic [NREQ-1:0]         o_done,
    output logic                    o_busy,
    output logic [OW-1:0]           o_owner,
    output logic                    o_incr,
    input  logic [5:0]              i_grey_code,
    input  logic                    i_err_clr,
    output logic                    o_step_err
);

    localparam int PW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [PW-1:0] PACE_LOAD = PW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_PACE, S_DONE} state_t;

    state_t            state;
    logic [OW-1:0]     ptr;
    logic [CNT_W-1:0]  remain;
    logic [PW-1:0]     pace_cnt;
    logic [5:0]        prev_code;
    logic              chk_vld;

    logic [OW-1:0]     win;
    logic              found;
    logic [OW-1:0]     cand;
    logic [NREQ-1:0]   grant;
    logic [CNT_W-1:0]  win_steps;
    logic              hs;

    // Pick the first valid requester searching upward from the last owner.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        grant = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = OW'((int'(ptr) + i) % NREQ);
            if (!found && i_req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (found && state == S_IDLE)
            grant[win] = 1'b1;
    end

    assign o_req_ready = grant;
    assign hs          = (state == S_IDLE) && found;
    assign win_steps   = i_req_steps[win*CNT_W +: CNT_W];

    // Scheduler FSM: grant, paced increment pulses, completion pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_IDLE;
            ptr      <= OW'(NREQ - 1);
            o_owner  <= '0;
            remain   <= '0;
            pace_cnt <= '0;
            o_incr   <= 1'b0;
            o_done   <= '0;
            o_busy   <= 1'b0;
        end else begin
            o_incr <= 1'b0;
            o_done <= '0;
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        o_owner <= win;
                        ptr     <= win;
                        remain  <= win_steps;
                        o_busy  <= 1'b1;
                        if (win_steps == '0) begin
                            state       <= S_DONE;
                            o_done[win] <= 1'b1;
                        end else begin
                            state  <= S_STEP;
                            o_incr <= 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    remain <= remain - 1'b1;
                    if (remain == CNT_W'(1)) begin
                        state           <= S_DONE;
                        o_done[o_owner] <= 1'b1;
                    end else if (GAP > 0) begin
                        state    <= S_PACE;
                        pace_cnt <= PACE_LOAD;
                    end else begin
                        o_incr <= 1'b1;
                    end
                end
                S_PACE: begin
                    if (pace_cnt == '0) begin
                        state  <= S_STEP;
                        o_incr <= 1'b1;
                    end else begin
                        pace_cnt <= pace_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Step checker: snapshot the code on each pulse, compare one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_code  <= '0;
            chk_vld    <= 1'b0;
            o_step_err <= 1'b0;
        end else begin
            chk_vld <= o_incr;
            if (o_incr)
                prev_code <= i_grey_code;
            // A new error takes priority over a simultaneous clear.
            if (chk_vld && $countones(i_grey_code ^ prev_code) != 1)
                o_step_err <= 1'b1;
            else if (i_err_clr)
                o_step_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_grey_step_sched.sv
// Directed bench for grey_step_sched: one GAP=1 instance for most scenarios,
// plus a GAP=0 / 7-bit-count instance for the 64-step wrap run.
module tb_grey_step_sched;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_err_clr;

    logic [3:0]  valid_a, ready_a, done_a;
    logic [23:0] steps_a;
    logic        busy_a, incr_a, err_a;
    logic [1:0]  owner_a;
    logic [5:0]  grey_a, bcnt_a, gforce_val;
    logic        gforce_en;

    logic [3:0]  valid_b, ready_b, done_b;
    logic [27:0] steps_b;
    logic        busy_b, incr_b, err_b;
    logic [1:0]  owner_b;
    logic [5:0]  grey_b, bcnt_b;

    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    grey_step_sched #(.NREQ(4), .CNT_W(6), .GAP(1)) dut_a (
        .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(valid_a),
        .i_req_steps(steps_a), .o_req_ready(ready_a), .o_done(done_a),
        .o_busy(busy_a), .o_owner(owner_a), .o_incr(incr_a),
        .i_grey_code(grey_a), .i_err_clr(i_err_clr), .o_step_err(err_a)
    );

    grey_step_sched #(.NREQ(4), .CNT_W(7), .GAP(0)) dut_b (
        .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(valid_b),
        .i_req_steps(steps_b), .o_req_ready(ready_b), .o_done(done_b),
        .o_busy(busy_b), .o_owner(owner_b), .o_incr(incr_b),
        .i_grey_code(grey_b), .i_err_clr(i_err_clr), .o_step_err(err_b)
    );

    // Gray counter models driven by the increment pulses.
    always @(posedge i_clk) begin
        if (i_reset) bcnt_a <= '0;
        else if (incr_a) bcnt_a <= bcnt_a + 6'd1;
    end
    always @(posedge i_clk) begin
        if (i_reset) bcnt_b <= '0;
        else if (incr_b) bcnt_b <= bcnt_b + 6'd1;
    end
    assign grey_a = gforce_en ? gforce_val : (bcnt_a ^ (bcnt_a >> 1));
    assign grey_b = bcnt_b ^ (bcnt_b >> 1);

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset;
        i_reset = 1'b1; i_err_clr = 1'b0; gforce_en = 1'b0; gforce_val = '0;
        valid_a = '0; steps_a = '0; valid_b = '0; steps_b = '0;
        tick; tick;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_a); end
        checks++; if (incr_a !== 1'b0) begin failures++; $display("FAIL rst_incr got=%b exp=0", incr_a); end
        checks++; if (done_a !== 4'b0) begin failures++; $display("FAIL rst_done got=%b exp=0000", done_a); end
        checks++; if (owner_a !== 2'd0) begin failures++; $display("FAIL rst_owner got=%0d exp=0", owner_a); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_a); end
        checks++; if (ready_a !== 4'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0000", ready_a); end
        i_reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        logic       ei, eb;
        logic [3:0] ed;
        valid_a = 4'b0001; steps_a[0 +: 6] = 6'd3;
        #1;
        checks++; if (ready_a !== 4'b0001) begin failures++; $display("FAIL basic_ready got=%b exp=0001", ready_a); end
        tick;
        valid_a = '0;
        for (int c = 1; c <= 7; c++) begin
            ei = (c == 1 || c == 3 || c == 5);
            ed = (c == 6) ? 4'b0001 : 4'b0000;
            eb = (c <= 6);
            checks++; if (incr_a !== ei) begin failures++; $display("FAIL basic_incr c=%0d got=%b exp=%b", c, incr_a, ei); end
            checks++; if (done_a !== ed) begin failures++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, done_a, ed); end
            checks++; if (busy_a !== eb) begin failures++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy_a, eb); end
            if (c == 6) begin
                checks++; if (grey_a !== 6'b000010) begin failures++; $display("FAIL basic_grey got=%b exp=000010", grey_a); end
            end
            tick;
        end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err_a); end
    endtask

    task automatic test_zero_steps;
        valid_a = 4'b0010; steps_a[6 +: 6] = 6'd0;
        #1;
        checks++; if (ready_a !== 4'b0010) begin failures++; $display("FAIL zero_ready got=%b exp=0010", ready_a); end
        tick;
        valid_a = '0;
        checks++; if (done_a !== 4'b0010) begin failures++; $display("FAIL zero_done got=%b exp=0010", done_a); end
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL zero_busy1 got=%b exp=1", busy_a); end
        checks++; if (incr_a !== 1'b0) begin failures++; $display("FAIL zero_incr got=%b exp=0", incr_a); end
        checks++; if (owner_a !== 2'd1) begin failures++; $display("FAIL zero_owner got=%0d exp=1", owner_a); end
        tick;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL zero_busy2 got=%b exp=0", busy_a); end
        checks++; if (done_a !== 4'b0) begin failures++; $display("FAIL zero_done2 got=%b exp=0000", done_a); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp;
        i_reset = 1'b1; tick; i_reset = 1'b0;
        valid_a = 4'hF; steps_a = {4{6'd1}};
        for (int g = 0; g < 6; g++) begin
            exp = 4'b0001 << (g % 4);
            #1;
            checks++; if (ready_a !== exp) begin failures++; $display("FAIL rr_ready g=%0d got=%b exp=%b", g, ready_a, exp); end
            tick;
            checks++; if (incr_a !== 1'b1) begin failures++; $display("FAIL rr_incr g=%0d got=%b exp=1", g, incr_a); end
            tick;
            checks++; if (done_a !== exp) begin failures++; $display("FAIL rr_done g=%0d got=%b exp=%b", g, done_a, exp); end
            checks++; if (owner_a !== 2'(g % 4)) begin failures++; $display("FAIL rr_owner g=%0d got=%0d exp=%0d", g, owner_a, g % 4); end
            tick;
        end
        valid_a = '0;
        tick;
    endtask

    task automatic test_step_err;
        i_reset = 1'b1; tick; i_reset = 1'b0;
        gforce_en = 1'b1; gforce_val = 6'b000001;
        valid_a = 4'b0001; steps_a[0 +: 6] = 6'd1;
        tick;
        valid_a = '0;
        checks++; if (incr_a !== 1'b1) begin failures++; $display("FAIL err_incr got=%b exp=1", incr_a); end
        tick;
        gforce_val = 6'b000010;
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL err_early got=%b exp=0", err_a); end
        tick;
        checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err_a); end
        tick;
        checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL err_hold got=%b exp=1", err_a); end
        i_err_clr = 1'b1; tick; i_err_clr = 1'b0;
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL err_clr got=%b exp=0", err_a); end
        // second run: new error lands in the same cycle as a clear
        valid_a = 4'b0001;
        tick;
        valid_a = '0;
        checks++; if (incr_a !== 1'b1) begin failures++; $display("FAIL err_incr2 got=%b exp=1", incr_a); end
        tick;
        gforce_val = 6'b000001; i_err_clr = 1'b1;
        tick;
        i_err_clr = 1'b0;
        checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL err_setwins got=%b exp=1", err_a); end
        i_err_clr = 1'b1; tick; i_err_clr = 1'b0;
        gforce_en = 1'b0;
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL err_clr2 got=%b exp=0", err_a); end
    endtask

    task automatic test_reset_abort;
        int n, bad;
        i_reset = 1'b1; tick; i_reset = 1'b0;
        valid_a = 4'b0100; steps_a[12 +: 6] = 6'd10;
        #1;
        checks++; if (ready_a !== 4'b0100) begin failures++; $display("FAIL abort_ready got=%b exp=0100", ready_a); end
        tick;
        valid_a = '0;
        n = 0;
        for (int c = 1; c <= 7; c++) begin
            if (incr_a === 1'b1) n++;
            tick;
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL abort_pre_incr got=%0d exp=4", n); end
        i_reset = 1'b1; tick; i_reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            if (incr_a !== 1'b0 || done_a !== 4'b0 || busy_a !== 1'b0) bad++;
            tick;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL abort_quiet got=%0d bad cycles exp=0", bad); end
        valid_a = 4'b1001; steps_a[0 +: 6] = 6'd0; steps_a[18 +: 6] = 6'd0;
        #1;
        checks++; if (ready_a !== 4'b0001) begin failures++; $display("FAIL abort_prio got=%b exp=0001", ready_a); end
        tick;
        valid_a = '0;
        checks++; if (owner_a !== 2'd0) begin failures++; $display("FAIL abort_owner got=%0d exp=0", owner_a); end
        checks++; if (done_a !== 4'b0001) begin failures++; $display("FAIL abort_done got=%b exp=0001", done_a); end
        tick;
    endtask

    task automatic test_wrap_gap0;
        logic [5:0] g0;
        int n, bad;
        g0 = grey_b;
        valid_b = 4'b0001; steps_b[0 +: 7] = 7'd64;
        #1;
        checks++; if (ready_b !== 4'b0001) begin failures++; $display("FAIL wrap_ready got=%b exp=0001", ready_b); end
        tick;
        valid_b = '0;
        n = 0; bad = 0;
        for (int c = 1; c <= 64; c++) begin
            if (incr_b === 1'b1) n++;
            if (done_b !== 4'b0) bad++;
            tick;
        end
        checks++; if (n !== 64) begin failures++; $display("FAIL wrap_incr got=%0d exp=64", n); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL wrap_early_done got=%0d exp=0", bad); end
        checks++; if (done_b !== 4'b0001) begin failures++; $display("FAIL wrap_done got=%b exp=0001", done_b); end
        checks++; if (incr_b !== 1'b0) begin failures++; $display("FAIL wrap_incr_end got=%b exp=0", incr_b); end
        checks++; if (grey_b !== g0) begin failures++; $display("FAIL wrap_grey got=%b exp=%b", grey_b, g0); end
        checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL wrap_err got=%b exp=0", err_b); end
        tick;
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL wrap_busy got=%b exp=0", busy_b); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_steps;
        test_round_robin;
        test_step_err;
        test_reset_abort;
        test_wrap_gap0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule

// File: doc/grey_step_sched.md
# grey_step_sched

Round-robin scheduler that shares one 6-bit Gray-code counter among NREQ requesters. Each requester submits a step count over a valid/ready handshake. The block drives the counter's increment input with paced single-cycle pulses and signals completion per requester. It also monitors the counter output and flags any step that changes other than exactly one bit.

## Interface
- NREQ, 4: number of requesters, 2..8.
- CNT_W, 6: width of each step-count field.
- GAP, 1: idle cycles inserted between consecutive increment pulses; 0 allowed.
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  NREQ  per-requester request valid.
- i_req_steps  in  NREQ*CNT_W  per-requester step count; requester k occupies bits [k*CNT_W +: CNT_W].
- o_req_ready  out  NREQ  handshake ready, one-hot or zero.
- o_done  out  NREQ  one-cycle completion pulse for the owning requester.
- o_busy  out  1  high whenever state is not IDLE.
- o_owner  out  clog2(NREQ)  index of the current or last owner.
- o_incr  out  1  increment pulse to the Gray counter.
- i_grey_code  in  6  Gray counter output.
- i_err_clr  in  1  clears o_step_err.
- o_step_err  out  1  sticky step-error flag.

## Operation
- Reset values: state IDLE; all outputs 0; o_owner 0; remaining count 0; round-robin last-owner pointer NREQ-1, so requester 0 has top priority.
- **IDLE**
  - o_req_ready is combinational: one-hot on the first valid requester searching upward from pointer+1 with wrap.
  - Handshake = valid & ready. On handshake: latch steps, set o_owner and pointer to the winner.
  - steps==0 goes to DONE; otherwise goes to STEP.
  - With no valid requester, the block stays in IDLE.
- **STEP**
  - o_incr=1 for exactly one cycle; remaining decrements.
  - If remaining was 1, go to DONE.
  - Otherwise, if GAP>0, go to PACE; if GAP==0, stay in STEP.
- **PACE**: o_incr=0 for GAP cycles, then return to STEP.
- **DONE**: o_done[o_owner]=1 for one cycle, then return to IDLE.
- o_req_ready is 0 in every state other than IDLE.
- Handshake rules:
  - A requester holds valid and steps stable until its ready.
  - i_req_steps is sampled only at the handshake; changes while not ready are ignored.
  - Dropping valid before ready is legal and has no effect.
- Step count range is 0..2^CNT_W-1. A 64-step run wraps the 6-bit Gray code to its start and is not an error.
- Step checker:
  - In each o_incr cycle, capture i_grey_code as previous.
  - On the following cycle, compare the current i_grey_code against previous. If popcount(xor)!=1, set o_step_err.
  - Back-to-back increments (GAP=0) are checked on every step.
- o_step_err is sticky and cleared by i_err_clr.
- If set and clear occur in the same cycle, set wins.
- i_reset clears o_step_err.
- Reset mid-operation: the run is aborted immediately, no further o_incr, no o_done, and the pointer returns to NREQ-1.

## Timing
- Handshake at cycle T with n>0:
  - o_incr at T+1+k*(GAP+1), for k=0..n-1.
  - o_done at T+1+(n-1)*(GAP+1)+1.
  - IDLE one cycle after o_done.
- Handshake at T with n=0: o_done at T+1, no o_incr.
- Earliest next handshake is the cycle after o_done, so per-request overhead is 2 cycles plus the steps.
- o_done coincides with the cycle in which i_grey_code shows the final step.
- Checker latency: for an o_incr at T, the comparison happens at T+1 and o_step_err is visible at T+2.
- o_busy rises the cycle after the handshake and falls the cycle after o_done.

## Test plan
1. NREQ=4, GAP=1, reset then release; req0 steps=3 handshake at T -> o_incr at T+1, T+3, T+5; o_done[0] at T+6; i_grey_code 000000->000001->000011->000010; o_step_err=0.
2. req1 steps=0 handshake at T -> no o_incr; o_done[1] at T+1; o_busy high only at T+1.
3. All four valid continuously with steps=1 from reset -> grant order 0,1,2,3,0,1; each o_done matches its owner; no requester is starved.
4. Test model forces i_grey_code 000001->000010 (two-bit change) after o_incr at T -> o_step_err=1 at T+2 and held; i_err_clr pulse clears it; clear coinciding with a new error leaves it set.
5. req2 steps=10 with i_reset asserted after the 4th o_incr -> no further o_incr, no o_done[2], o_busy=0; next simultaneous req0 and req3 -> req0 granted.
6. GAP=0, req0 steps=64 -> 64 consecutive o_incr cycles; i_grey_code returns to the start value; o_done[0] on the cycle after the last o_incr; o_step_err=0.
